pinto_frame_ctrl: RTL and testbench

Frame sequencer that sits directly downstream of the PINTO enable register on the AHB-lite bus. It consumes the `PINTO_en` level and gates a pixel stream into the PINTO datapath, counting pixels and lines to insert frame/line markers. Frames are always completed whole. Frame completion is reported as a one-cycle `frame_done` pulse and a running frame count.

---
 rtl/pinto_frame_ctrl.sv | 137 +++++++++++++
 tb/tb_pinto_frame_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pinto_frame_ctrl.sv
// pinto_frame_ctrl: frame sequencer between the PINTO enable register and the
// PINTO datapath. Gates a pixel stream through a one-entry output register,
// tags first-of-frame / end-of-line / end-of-frame, and counts finished frames.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for PINTO_en, no pixels accepted
//   ST_RUN   | accepting pixels of the current frame
//   ST_DRAIN | last pixel accepted, waiting for it to leave the output reg
//
// Once a frame has started it always runs to completion; PINTO_en is only
// looked at when leaving IDLE and when leaving DRAIN.

module pinto_frame_ctrl #(
    parameter int DW    = 8,
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int CNT_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             PINTO_en,
    input  logic             s_valid,
    input  logic [DW-1:0]    s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [DW-1:0]    m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_eof,
    input  logic             m_ready,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [XW-1:0]    X_LAST  = XW'(H_ACT - 1);
    localparam logic [YW-1:0]    Y_LAST  = YW'(V_ACT - 1);
    localparam logic [XW-1:0]    X_ONE   = XW'(1);
    localparam logic [YW-1:0]    Y_ONE   = YW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          in_xfer;
    logic          out_xfer;
    logic          x_last;
    logic          y_last;
    logic          eof_taken;

    // Input accept is combinational from m_ready so a stalled output blocks
    // the input in the same cycle.
    assign s_ready   = (state == ST_RUN) & (~m_valid | m_ready);
    assign busy      = (state != ST_IDLE);
    assign in_xfer   = s_valid & s_ready;
    assign out_xfer  = m_valid & m_ready;
    assign x_last    = (x == X_LAST);
    assign y_last    = (y == Y_LAST);
    assign eof_taken = (state == ST_DRAIN) & out_xfer & m_eof;

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (PINTO_en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (in_xfer && x_last && y_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (eof_taken) state_nxt = PINTO_en ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Column/line counters; the final pixel of a frame wraps both to zero.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            x <= '0;
            y <= '0;
        end else if (in_xfer) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + Y_ONE;
            end else begin
                x <= x + X_ONE;
            end
        end
    end

    // One-entry output register; markers come from the pre-increment counters.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (in_xfer) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_sof   <= (x == '0) & (y == '0);
            m_eol   <= x_last;
            m_eof   <= x_last & y_last;
        end else if (out_xfer) begin
            m_valid <= 1'b0;
        end
    end

    // Frame completion pulse and wrapping frame counter.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= eof_taken;
            if (eof_taken) frame_cnt <= frame_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pinto_frame_ctrl.sv
// Directed bench for pinto_frame_ctrl with 4x2 frames. frame_cnt is built
// 2 bits wide so the counter wrap is reached within a few frames.

module tb_pinto_frame_ctrl;

    localparam int DW = 8;

    logic          HCLK;
    logic          HRESET;
    logic          PINTO_en;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic          m_ready;
    logic          busy;
    logic          frame_done;
    logic [1:0]    frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pinto_frame_ctrl #(
        .DW(DW), .H_ACT(4), .V_ACT(2), .XW(2), .YW(1), .CNT_W(2)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PINTO_en(PINTO_en),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
        .m_eof(m_eof), .m_ready(m_ready), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard / monitor state
    logic [10:0] sb[$];
    logic [1:0]  fc_q[$];
    int          pix_idx = 0;
    int          fd_count = 0;
    int          cyc_n = 0;
    int          t_eof = 0;
    bit          t_eof_ok = 0;
    bit          bubble_en = 0;
    bit          prev_acc = 0;
    bit          prev_stall = 0;
    bit          exp_fd = 0;
    logic [DW-1:0] prev_data_in;
    logic [10:0] stall_word;
    logic [10:0] w;

    // Monitor: everything is sampled on the falling edge.
    always @(negedge HCLK) begin
        cyc_n++;
        chk("frame_done", frame_done, exp_fd);
        if (prev_acc) begin
            chk("lat_valid", m_valid, 1);
            chk("lat_data", m_data, prev_data_in);
        end
        if (prev_stall) chk("stall_hold", {m_data, m_sof, m_eol, m_eof}, stall_word);
        if (frame_done) begin
            fd_count++;
            fc_q.push_back(frame_cnt);
        end
        if (HRESET) begin
            sb.delete();
            pix_idx    = 0;
            prev_acc   = 0;
            prev_stall = 0;
            exp_fd     = 0;
        end else begin
            if (m_valid && !m_ready) chk("s_ready_bp", s_ready, 0);
            prev_stall = m_valid && !m_ready;
            stall_word = {m_data, m_sof, m_eol, m_eof};
            exp_fd     = m_valid && m_ready && m_eof;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_extra_out", 1, 0);
                end else begin
                    w = sb.pop_front();
                    chk("out_pix", {m_data, m_sof, m_eol, m_eof}, w);
                end
            end
            prev_acc     = s_valid && s_ready;
            prev_data_in = s_data;
            if (prev_acc) begin
                sb.push_back({s_data, pix_idx == 0, (pix_idx % 4) == 3, pix_idx == 7});
                if (bubble_en) begin
                    if (pix_idx == 0 && t_eof_ok) chk("bubble", cyc_n - t_eof, 2);
                    if (pix_idx == 7) begin
                        t_eof    = cyc_n;
                        t_eof_ok = 1;
                    end
                end
                pix_idx = (pix_idx + 1) % 8;
            end
        end
    end

    // Backpressure pattern generator
    bit       bp_en = 0;
    int       bp_k = 0;
    bit [3:0] bp_pat = 4'b1001;
    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            if (bp_en) begin
                m_ready = bp_pat[bp_k];
                bp_k    = (bp_k + 1) % 4;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bit acc;
            acc     = 0;
            s_valid = 1'b1;
            s_data  = 8'(base + i);
            for (int k = 0; k < 50 && !acc; k++) begin
                @(negedge HCLK);
                acc = s_ready;
                @(posedge HCLK);
                #1;
            end
            if (!acc) chk("send_timeout", 0, 1);
        end
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 40 && fd_count < target; k++) cyc(1);
        chk("done_wait", fd_count >= target, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_markers", {m_sof, m_eol, m_eof}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
    endtask

    initial begin
        int fd0;
        HRESET   = 1'b1;
        PINTO_en = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b1;

        // Reset and single frame
        cyc(2);
        chk_reset_vals();
        HRESET   = 1'b0;
        PINTO_en = 1'b1;
        cyc(1);
        chk("run_busy", busy, 1);
        chk("run_s_ready", s_ready, 1);
        send(8'h10, 8);
        s_valid = 1'b0;
        wait_done(1);
        cyc(3);
        chk("t1_done_pulses", fd_count, 1);
        chk("t1_frame_cnt", frame_cnt, 1);

        // Backpressure
        bp_k  = 0;
        bp_en = 1;
        send(8'h20, 8);
        s_valid = 1'b0;
        wait_done(2);
        bp_en   = 0;
        m_ready = 1'b1;
        cyc(2);
        chk("t2_frame_cnt", frame_cnt, 2);
        chk("t2_sb_empty", sb.size(), 0);

        // Enable drop mid-frame
        send(8'h30, 3);
        PINTO_en = 1'b0;
        send(8'h33, 5);
        s_valid = 1'b0;
        wait_done(3);
        cyc(2);
        chk("t3_frame_cnt", frame_cnt, 3);
        chk("t3_busy", busy, 0);
        s_valid = 1'b1;
        s_data  = 8'h99;
        for (int k = 0; k < 3; k++) begin
            chk("t3_s_ready_idle", s_ready, 0);
            cyc(1);
        end
        s_valid = 1'b0;
        chk("t3_sb_empty", sb.size(), 0);

        // Reset mid-frame
        PINTO_en = 1'b1;
        cyc(1);
        chk("t4_busy", busy, 1);
        send(8'h40, 5);
        s_valid = 1'b0;
        HRESET  = 1'b1;
        cyc(1);
        chk_reset_vals();
        HRESET = 1'b0;
        cyc(1);
        fd0 = fd_count;
        send(8'h50, 8);
        s_valid = 1'b0;
        wait_done(fd0 + 1);
        cyc(2);
        chk("t4_frame_cnt", frame_cnt, 1);

        // Continuous frames, bubble spacing, counter wrap (2-bit counter)
        fc_q.delete();
        t_eof_ok  = 0;
        bubble_en = 1;
        fd0 = fd_count;
        send(8'h60, 24);
        s_valid = 1'b0;
        wait_done(fd0 + 3);
        bubble_en = 0;
        cyc(2);
        chk("t5_pulses", fc_q.size(), 3);
        if (fc_q.size() == 3) begin
            chk("t5_cnt_f1", fc_q[0], 2);
            chk("t5_cnt_f2", fc_q[1], 3);
            chk("t5_cnt_wrap", fc_q[2], 0);
        end
        chk("t5_frame_cnt", frame_cnt, 0);
        chk("t5_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
